seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//   Programmable serial bit-sequence detector. Generalises the fixed 4-bit detector
//   with a parametrised pattern length, a runtime-loadable pattern and care-mask,
//   selectable overlapping or non-overlapping detection, and a sample-enable input.
//   Sits directly on a 1-bit serial data stream and pulses done on each match.
// PARAMETERS
//   PAT_W    4        pattern length in bits (2..32)
//   DEF_PAT  4'b1011  pattern after reset, oldest bit in MSB, width PAT_W
//   CNT_W    8        match counter width (only with SEQ_DET_CNT_EN)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   en         in   1      d is sampled only on edges where en=1
//   d          in   1      serial data input
//   overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//   cfg_load   in   1      load cfg_pat/cfg_care this edge
//   cfg_pat    in   PAT_W  new pattern, MSB = first bit received
//   cfg_care   in   PAT_W  per-bit compare enable (0 = don't-care)
//   done       out  1      registered one-cycle match pulse
//   match_cnt  out  CNT_W  saturating match count (SEQ_DET_CNT_EN only)
// BEHAVIOUR
//   - Reset (rst=1 at an edge): pat=DEF_PAT, care=all ones, hist=0, fill=0,
//     done=0, match_cnt=0. rst has priority over every other input.
//   - hist: PAT_W-bit shift register, hist <= {hist[PAT_W-2:0], d} on each
//     edge with en=1. hist[PAT_W-1] is the oldest bit.
//   - fill: counts valid history bits (0..PAT_W) and saturates at PAT_W.
//     It increments on each sampled bit.
//   - Match condition (evaluated on the new history value):
//     fill_next==PAT_W and ((hist_next ^ pat) & care)==0.
//   - done is driven from a flop. It is high for exactly the one cycle
//     following the edge that sampled the last pattern bit (latency 1).
//     done=0 on edges with en=0.
//   - overlap=1: history is kept after a match, so 1011011 gives 2 matches.
//     overlap=0: a match sets fill<=0 (hist is kept but ignored), so the next
//     match needs PAT_W fresh bits.
//   - overlap is sampled every edge. Changing it mid-stream affects only
//     matches from that edge on.
//   - cfg_load=1 (and rst=0): pat<=cfg_pat, care<=cfg_care, fill<=0, done<=0.
//     The d sample that edge is discarded, whatever en is.
//   - care=0 (all don't-care): a match fires each time fill reaches PAT_W.
//     Counting restarts per the overlap rule.
//   - en=0: hist, fill and match_cnt hold.
//   - Two-state FSM on fill: FILLING (fill<PAT_W) and ARMED (fill==PAT_W).
//     ARMED goes to FILLING on a non-overlap match or on cfg_load.
// CONFIGURATION
//   SEQ_DET_CNT_EN defined: match_cnt increments on every cycle done is set.
//     It saturates at 2**CNT_W-1 and is cleared by rst only, not by cfg_load.
//   SEQ_DET_CNT_EN undefined: counter logic is removed. match_cnt is tied to
//     0 and the port stays present.
// TESTING
//   1. Reset, DEF_PAT=1011, overlap=1, en=1, d=1,0,1,1,0,1,1 -> done high after
//      the 4th and 7th bits only.
//   2. Same stream as test 1 with overlap=0 -> done after the 4th bit only,
//      with no pulse after the 7th.
//   3. cfg_load pat=0110, care=1111, then d=0,1,1,0,1,1,0 -> done after bits
//      4 and 7 (overlap=1).
//   4. care=1001, pat=1001, d=1,1,1,1 -> done after bit 4. With d=1,0,1,0 ->
//      no done.
//   5. Toggle en low between bits of 1011 -> done occurs only after the 4th
//      enabled bit. Assert rst mid-pattern -> fill restarts and no spurious
//      done appears.
//   6. With SEQ_DET_CNT_EN and CNT_W=2, produce 5 matches -> match_cnt=3
//      (saturated). Without the macro -> match_cnt=0 throughout.

Source files
------------

// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
//   Programmable serial bit-sequence detector.
//   - Shifts the serial input into a PAT_W-bit history on each enabled edge.
//   - Compares the history against a loadable pattern under a per-bit care
//     mask.
//   - Pulses done for one cycle on each match.
//   - Supports overlapping and non-overlapping detection.
//
// Optional feature
//   Define SEQ_DET_CNT_EN to build a saturating match counter. Without the
//   macro, match_cnt is tied to zero.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset (highest priority)
//   en         in   1      sample enable for d
//   d          in   1      serial data input
//   overlap    in   1      1 = overlapping, 0 = non-overlapping detection
//   cfg_load   in   1      load cfg_pat/cfg_care; that edge's d is discarded
//   cfg_pat    in   PAT_W  new pattern, MSB = first bit received
//   cfg_care   in   PAT_W  per-bit compare enable (0 = don't-care)
//   done       out  1      registered one-cycle match pulse
//   match_cnt  out  CNT_W  saturating match count (zero without the macro)
// ---------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_care,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int              FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FULL = FW'(PAT_W);
    localparam logic [FW-1:0]   ONE  = FW'(1);

    // FILLING: fewer than PAT_W valid history bits; ARMED: history is full.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    state_t           state_r;
    logic [PAT_W-1:0] pat_r;
    logic [PAT_W-1:0] care_r;
    logic [PAT_W-1:0] hist_r;
    logic [FW-1:0]    fill_r;

    logic [PAT_W-1:0] hist_next_s;
    logic [FW-1:0]    fill_next_s;
    logic             match_s;

    // Next history/fill values and the match test on the post-shift history.
    always_comb begin
        hist_next_s = {hist_r[PAT_W-2:0], d};
        fill_next_s = FULL;
        match_s     = 1'b0;
        case (state_r)
            ARMED:   fill_next_s = FULL;
            FILLING: fill_next_s = fill_r + ONE;
            default: fill_next_s = FULL;
        endcase
        if (fill_next_s == FULL) begin
            match_s = (((hist_next_s ^ pat_r) & care_r) == {PAT_W{1'b0}});
        end else begin
            match_s = 1'b0;
        end
    end

    // Detector FSM: config load, history shift, fill tracking, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FILLING;
            pat_r   <= DEF_PAT;
            care_r  <= {PAT_W{1'b1}};
            hist_r  <= {PAT_W{1'b0}};
            fill_r  <= {FW{1'b0}};
            done    <= 1'b0;
        end else if (cfg_load) begin
            // Loading a new pattern invalidates the collected history;
            // the d sample on this edge is dropped.
            state_r <= FILLING;
            pat_r   <= cfg_pat;
            care_r  <= cfg_care;
            fill_r  <= {FW{1'b0}};
            done    <= 1'b0;
        end else if (en) begin
            hist_r <= hist_next_s;
            done   <= match_s;
            if (match_s && !overlap) begin
                // Non-overlapping: the next match needs PAT_W fresh bits.
                state_r <= FILLING;
                fill_r  <= {FW{1'b0}};
            end else begin
                state_r <= (fill_next_s == FULL) ? ARMED : FILLING;
                fill_r  <= fill_next_s;
            end
        end else begin
            done <= 1'b0;
        end
    end

`ifdef SEQ_DET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating match counter; counts the same edges that set done.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= {CNT_W{1'b0}};
        end else if (!cfg_load && en && match_s && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + CNT_ONE;
        end else begin
            match_cnt <= match_cnt;
        end
    end
`else
    assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_prog
//   Self-checking bench for seq_detect_prog (PAT_W=4, DEF_PAT=1011, CNT_W=2).
//   Directed scenarios followed by a randomized stream. The reference model
//   keeps a queue of freshly sampled bits and tests the pattern bit by bit.
// ---------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAXV = (1 << CNT_W) - 1;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             en;
    logic             d;
    logic             overlap;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [PAT_W-1:0] cfg_care;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat;
    logic [PAT_W-1:0] m_care;
    logic             exp_done;
    int               exp_cnt;

    seq_detect_prog #(
        .PAT_W  (PAT_W),
        .DEF_PAT(4'b1011),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d        (d),
        .overlap  (overlap),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_care (cfg_care),
        .done     (done),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        bit hit;
        exp_done = 1'b0;
        if (rst) begin
            m_q.delete();
            m_pat   = 4'b1011;
            m_care  = 4'b1111;
            exp_cnt = 0;
        end else if (cfg_load) begin
            m_q.delete();
            m_pat  = cfg_pat;
            m_care = cfg_care;
        end else if (en) begin
            m_q.push_back(d);
            if (m_q.size() > PAT_W) void'(m_q.pop_front());
            if (m_q.size() == PAT_W) begin
                hit = 1'b1;
                for (int i = 0; i < PAT_W; i++) begin
                    if (m_care[PAT_W-1-i] && (m_q[i] != m_pat[PAT_W-1-i])) hit = 1'b0;
                end
                exp_done = hit;
                if (hit) begin
                    if (!overlap) m_q.delete();
                    if (CNT_ON && exp_cnt < CNT_MAXV) exp_cnt++;
                end
            end
        end
    endtask

    // One clock edge: update the model, then compare outputs 1 time unit later.
    task automatic tick(input string tag);
        logic [CNT_W-1:0] exp_cnt_v;
        @(posedge clk);
        model_edge();
        #1;
        exp_cnt_v = CNT_W'(exp_cnt);
        checks++;
        assert (done === exp_done) else begin
            errors++;
            $error("FAIL %s done: got %0b expected %0b", tag, done, exp_done);
        end
        checks++;
        assert (match_cnt === exp_cnt_v) else begin
            errors++;
            $error("FAIL %s match_cnt: got %0d expected %0d", tag, match_cnt, exp_cnt_v);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        tick(tag);
        rst = 1'b0;
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] c, input string tag);
        cfg_load = 1'b1; cfg_pat = p; cfg_care = c; en = 1'b1; d = 1'b1;
        tick(tag);
        cfg_load = 1'b0;
    endtask

    // Feed n bits of seq MSB-first with en=1.
    task automatic feed(input logic [15:0] seq, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            en = 1'b1; d = seq[i];
            tick(tag);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; d = 1'b0; overlap = 1'b1;
        cfg_load = 1'b0; cfg_pat = 4'b0000; cfg_care = 4'b0000;
        @(negedge clk);

        // Reset state and test 1: overlapping default pattern
        do_reset("reset");
        overlap = 1'b1;
        feed(16'b1011011, 7, "t1_overlap");

        // Test 2: non-overlapping on the same stream
        do_reset("t2_reset");
        overlap = 1'b0;
        feed(16'b1011011, 7, "t2_nonoverlap");

        // Test 3: loaded pattern 0110
        overlap = 1'b1;
        load(4'b0110, 4'b1111, "t3_load");
        feed(16'b0110110, 7, "t3_pat0110");

        // Test 4: care mask 1001
        load(4'b1001, 4'b1001, "t4_load");
        feed(16'b1111, 4, "t4_care_hit");
        load(4'b1001, 4'b1001, "t4_reload");
        feed(16'b1010, 4, "t4_care_miss");

        // All don't-care: fires whenever fill reaches PAT_W
        overlap = 1'b0;
        load(4'b0000, 4'b0000, "dc_load");
        feed(16'b10010110, 8, "dc_nonoverlap");

        // Test 5: en toggled between bits, then reset mid-pattern
        do_reset("t5_reset");
        overlap = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pv;
            pv = 4'b1011;
            en = 1'b1; d = pv[i];
            tick("t5_en_bit");
            en = 1'b0; d = $urandom_range(0, 1);
            tick("t5_en_gap");
            tick("t5_en_gap2");
        end
        feed(16'b10, 2, "t5_pre_rst");
        do_reset("t5_mid_rst");
        feed(16'b11, 2, "t5_post_rst");
        feed(16'b1011, 4, "t5_after");

        // Test 6: five matches with a 2-bit counter
        do_reset("t6_reset");
        overlap = 1'b0;
        feed(16'b1011, 4, "t6_m1");
        feed(16'b1011, 4, "t6_m2");
        feed(16'b1011, 4, "t6_m3");
        feed(16'b1011, 4, "t6_m4");
        load(4'b1011, 4'b1111, "t6_load_keeps_cnt");
        feed(16'b1011, 4, "t6_m5");

        // Randomized stream with occasional reconfiguration and reset
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            cfg_load = ($urandom_range(0, 63) == 0);
            if (cfg_load) begin
                cfg_pat  = 4'($urandom_range(0, 15));
                cfg_care = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
            end
            if ($urandom_range(0, 15) == 0) overlap = ~overlap;
            en = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            tick("random");
        end
        rst = 1'b0; cfg_load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
